// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped serial controller: window addresses,
// status bit positions, FSM state encodings and the baud divider helper.
package uart_mmio_pkg;

    localparam logic [31:0] SERIAL_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] SERIAL_STAT_ADDR = 32'hBFD0_03FC;

    localparam int STAT_TX_RDY   = 0;
    localparam int STAT_RX_AVAIL = 1;
    localparam int STAT_OVR      = 2;
    localparam int STAT_FRM      = 3;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_START = 2'd1;
    localparam fsm_state_t ST_DATA  = 2'd2;
    localparam fsm_state_t ST_STOP  = 2'd3;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with combinational head; push while full is accepted only when a
// pop happens in the same cycle.
module uart_byte_fifo
    import uart_mmio_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_10M,
    input  logic                     reset_of_clk10M,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count_r == (AW + 1)'(0));
    assign full      = (count_r == (AW + 1)'(DEPTH));
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    always_ff @(posedge clk_10M) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 serial controller: bus decode, TX/RX byte FIFOs, and the
// bit-level serializer/deserializer driving txd/rxd.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int          CLK_HZ     = 10000000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] ADDR_DATA  = SERIAL_DATA_ADDR,
    parameter logic [31:0] ADDR_STAT  = SERIAL_STAT_ADDR
) (
    input  logic        clk_10M,
    input  logic        reset_of_clk10M,
    input  logic        bus_ce_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_i,
    input  logic [3:0]  bus_sel_i,
    input  logic [31:0] bus_wdata_i,
    output logic [31:0] bus_rdata_o,
    output logic        bus_hit_o,
    output logic        txd,
    input  logic        rxd
);

    localparam int DIV  = calc_div(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int FAW  = $clog2(FIFO_DEPTH);

    logic hit_data_s, hit_stat_s, rd_data_s, rd_stat_s, wr_data_s;
    logic unused_bus_bits_s;
    logic tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic rx_push_s, rx_full_s, rx_empty_s;
    logic [7:0] tx_head_s, rx_head_s;
    logic [FAW:0] tx_count_s, rx_count_s;
    logic [3:0] stat_s;
    logic ovr_set_s, frm_set_s, tx_last_s, rx_last_s;

    fsm_state_t tx_state_r, rx_state_r;
    logic [CW-1:0] tx_cnt_r, rx_cnt_r;
    logic [2:0] tx_bit_r, rx_bit_r;
    logic [7:0] tx_shift_r, rx_shift_r;
    logic txd_r, rx_meta_r, rx_sync_r, rx_prev_r, ovr_r, frm_r;

    assign hit_data_s        = bus_ce_i && (bus_addr_i == ADDR_DATA);
    assign hit_stat_s        = bus_ce_i && (bus_addr_i == ADDR_STAT);
    assign bus_hit_o         = hit_data_s || hit_stat_s;
    assign rd_data_s         = hit_data_s && !bus_we_i;
    assign rd_stat_s         = hit_stat_s && !bus_we_i;
    assign wr_data_s         = hit_data_s && bus_we_i && bus_sel_i[0];
    assign unused_bus_bits_s = ^{bus_wdata_i[31:8], bus_sel_i[3:1]};
    assign tx_push_s         = wr_data_s && (!tx_full_s || tx_pop_s);
    assign tx_last_s         = (tx_cnt_r == CW'(DIV - 1));
    assign rx_last_s         = (rx_cnt_r == CW'(DIV - 1));
    assign txd               = txd_r;

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_10M         (clk_10M),
        .reset_of_clk10M (reset_of_clk10M),
        .push            (tx_push_s),
        .push_data       (bus_wdata_i[7:0]),
        .pop             (tx_pop_s),
        .full            (tx_full_s),
        .empty           (tx_empty_s),
        .head            (tx_head_s),
        .count           (tx_count_s)
    );

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_10M         (clk_10M),
        .reset_of_clk10M (reset_of_clk10M),
        .push            (rx_push_s),
        .push_data       (rx_shift_r),
        .pop             (rd_data_s),
        .full            (rx_full_s),
        .empty           (rx_empty_s),
        .head            (rx_head_s),
        .count           (rx_count_s)
    );

    always_comb begin
        stat_s                = 4'h0;
        stat_s[STAT_TX_RDY]   = (tx_count_s != (FAW + 1)'(FIFO_DEPTH));
        stat_s[STAT_RX_AVAIL] = (rx_count_s != (FAW + 1)'(0));
        stat_s[STAT_OVR]      = ovr_r;
        stat_s[STAT_FRM]      = frm_r;
        if (hit_data_s) begin
            bus_rdata_o = {24'h0, rx_empty_s ? 8'h00 : rx_head_s};
        end else if (hit_stat_s) begin
            bus_rdata_o = {28'h0, stat_s};
        end else begin
            bus_rdata_o = 32'h0;
        end
    end

    // The STOP-state pop lets a queued byte follow without an idle cycle.
    always_comb begin
        tx_pop_s = 1'b0;
        if (tx_state_r == ST_IDLE) begin
            tx_pop_s = !tx_empty_s;
        end else if ((tx_state_r == ST_STOP) && tx_last_s) begin
            tx_pop_s = !tx_empty_s;
        end else begin
            tx_pop_s = 1'b0;
        end
    end

    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
        end else begin
            case (tx_state_r)
                ST_IDLE: begin
                    if (tx_pop_s) begin
                        tx_shift_r <= tx_head_s;
                        tx_cnt_r   <= '0;
                        tx_state_r <= ST_START;
                        txd_r      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_last_s) begin
                        tx_cnt_r   <= '0;
                        tx_bit_r   <= 3'd0;
                        tx_state_r <= ST_DATA;
                        txd_r      <= tx_shift_r[0];
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_last_s) begin
                        tx_cnt_r <= '0;
                        if (tx_bit_r == 3'd7) begin
                            tx_state_r <= ST_STOP;
                            txd_r      <= 1'b1;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            txd_r      <= tx_shift_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (tx_last_s) begin
                        tx_cnt_r <= '0;
                        if (tx_pop_s) begin
                            tx_shift_r <= tx_head_s;
                            tx_state_r <= ST_START;
                            txd_r      <= 1'b0;
                        end else begin
                            tx_state_r <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CW'(1);
                    end
                end
                default: begin
                    tx_state_r <= ST_IDLE;
                    txd_r      <= 1'b1;
                end
            endcase
        end
    end

    // Synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign rx_push_s = (rx_state_r == ST_STOP) && rx_last_s && rx_sync_r;
    assign frm_set_s = (rx_state_r == ST_STOP) && rx_last_s && !rx_sync_r;
    assign ovr_set_s = rx_push_s && rx_full_s && !rd_data_s;

    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            case (rx_state_r)
                ST_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt_r == CW'(HALF - 1)) begin
                        rx_cnt_r   <= '0;
                        rx_bit_r   <= 3'd0;
                        rx_state_r <= rx_sync_r ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_last_s) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= ST_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_last_s) begin
                        rx_cnt_r   <= '0;
                        rx_state_r <= ST_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CW'(1);
                    end
                end
                default: rx_state_r <= ST_IDLE;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle as a clearing read wins.
    always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
        if (reset_of_clk10M) begin
            ovr_r <= 1'b0;
            frm_r <= 1'b0;
        end else begin
            ovr_r <= ovr_set_s ? 1'b1 : (rd_stat_s ? 1'b0 : ovr_r);
            frm_r <= frm_set_s ? 1'b1 : (rd_stat_s ? 1'b0 : frm_r);
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed + randomized bench for uart_mmio with a queue-based reference model
// of the RX FIFO/flags and a frame-level model of the TX line.
module tb_uart_mmio;

    localparam logic [31:0] A_DATA = 32'hBFD0_03F8;
    localparam logic [31:0] A_STAT = 32'hBFD0_03FC;
    localparam int          BIT    = 87;
    localparam int          FRAME  = 10 * BIT;

    logic        clk_10M = 1'b0;
    logic        reset_of_clk10M;
    logic        bus_ce, bus_we, bus_hit, txd, rxd;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] rx_q[$];
    logic       ovr_m = 1'b0;
    logic       frm_m = 1'b0;

    always #50 clk_10M = ~clk_10M;

    always @(posedge clk_10M) cyc <= cyc + 1;

    uart_mmio dut (
        .clk_10M         (clk_10M),
        .reset_of_clk10M (reset_of_clk10M),
        .bus_ce_i        (bus_ce),
        .bus_we_i        (bus_we),
        .bus_addr_i      (bus_addr),
        .bus_sel_i       (bus_sel),
        .bus_wdata_i     (bus_wdata),
        .bus_rdata_o     (bus_rdata),
        .bus_hit_o       (bus_hit),
        .txd             (txd),
        .rxd             (rxd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk_10M);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        bus_ce = 1'b1; bus_we = 1'b0; bus_addr = addr; bus_sel = 4'hF;
        #1;
        data = bus_rdata;
        hit  = bus_hit;
        @(negedge clk_10M);
        bus_ce = 1'b0; bus_addr = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [7:0] d, input logic [3:0] sel);
        bus_ce = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_sel = sel; bus_wdata = {24'h0, d};
        @(negedge clk_10M);
        bus_ce = 1'b0; bus_we = 1'b0; bus_addr = 32'h0;
    endtask

    task automatic read_stat(input string tag, input logic tx_rdy);
        logic [31:0] d;
        logic        h;
        logic [31:0] exp;
        exp = {28'h0, frm_m, ovr_m, (rx_q.size() != 0), tx_rdy};
        bus_read(A_STAT, d, h);
        check(tag, d, exp);
        ovr_m = 1'b0;
        frm_m = 1'b0;
    endtask

    task automatic read_data(input string tag);
        logic [31:0] d;
        logic        h;
        logic [31:0] exp;
        exp = 32'h0;
        if (rx_q.size() != 0) exp = {24'h0, rx_q.pop_front()};
        bus_read(A_DATA, d, h);
        check(tag, d, exp);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk_10M);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BIT) @(negedge clk_10M);
        end
        rxd = stop;
        repeat (BIT) @(negedge clk_10M);
        rxd = 1'b1;
        repeat (10) @(negedge clk_10M);
        if (stop) begin
            if (rx_q.size() < 16) rx_q.push_back(d);
            else ovr_m = 1'b1;
        end else begin
            frm_m = 1'b1;
        end
    endtask

    // Frame f relative to t0 (negedge after the first push): bit b spans cycles
    // t0+870f+87b+1 .. t0+870f+87b+87.
    task automatic check_tx_frame(input int t0, input int f, input logic [7:0] d);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            wait_until(t0 + FRAME * f + BIT * b + 44);
            check($sformatf("tx_mid_f%0d_b%0d", f, b), 32'(txd), 32'(bits[b]));
            wait_until(t0 + FRAME * f + BIT * b + BIT);
            check($sformatf("tx_end_f%0d_b%0d", f, b), 32'(txd), 32'(bits[b]));
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        h;
        logic [7:0]  rb;
        int          t0;

        reset_of_clk10M = 1'b1;
        rxd = 1'b1; bus_ce = 1'b0; bus_we = 1'b0;
        bus_addr = 32'h0; bus_sel = 4'h0; bus_wdata = 32'h0;
        repeat (3) @(negedge clk_10M);
        check("rst_txd", 32'(txd), 32'h1);
        reset_of_clk10M = 1'b0;
        @(negedge clk_10M);

        read_stat("rst_stat", 1'b1);
        read_data("rst_data_empty");
        check("idle_txd", 32'(txd), 32'h1);

        bus_read(A_DATA, d, h);
        check("hit_data", 32'(h), 32'h1);
        bus_read(32'hBFD0_0000 | ($urandom & 32'h0000_03F0), d, h);
        check("nohit_hit", 32'(h), 32'h0);
        check("nohit_rdata", d, 32'h0);

        bus_write(A_DATA, 8'hAA, 4'b1110);
        bus_write(A_STAT, 8'hFF, 4'hF);
        repeat (150) @(negedge clk_10M);
        check("sel0_no_tx", 32'(txd), 32'h1);
        read_stat("sel0_stat", 1'b1);

        bus_write(A_DATA, 8'h55, 4'h1);
        t0 = cyc;
        check("tx55_pre", 32'(txd), 32'h1);
        wait_until(t0 + 1);
        check("tx55_start_edge", 32'(txd), 32'h0);
        check_tx_frame(t0, 0, 8'h55);
        wait_until(t0 + FRAME + 20);
        check("tx55_idle", 32'(txd), 32'h1);

        rb = 8'($urandom_range(0, 255));
        bus_write(A_DATA, rb, 4'hF);
        t0 = cyc;
        check_tx_frame(t0, 0, rb);
        wait_until(t0 + FRAME + 5);

        for (int i = 0; i < 17; i++) begin
            bus_ce = 1'b1; bus_we = 1'b1; bus_addr = A_DATA; bus_sel = 4'h1;
            bus_wdata = 32'(i);
            @(negedge clk_10M);
            if (i == 0) t0 = cyc;
        end
        bus_ce = 1'b0; bus_we = 1'b0;
        read_stat("burst_full_stat", 1'b0);
        for (int f = 0; f < 17; f++) check_tx_frame(t0, f, 8'(f));
        wait_until(t0 + 17 * FRAME + 3);
        check("burst_idle_txd", 32'(txd), 32'h1);
        read_stat("burst_done_stat", 1'b1);

        bus_write(A_DATA, 8'h00, 4'h1);
        repeat (300) @(negedge clk_10M);
        check("midrst_pre_txd", 32'(txd), 32'h0);
        #13 reset_of_clk10M = 1'b1;
        #1 check("midrst_async_txd", 32'(txd), 32'h1);
        @(negedge clk_10M);
        reset_of_clk10M = 1'b0;
        repeat (200) @(negedge clk_10M);
        check("midrst_idle_txd", 32'(txd), 32'h1);
        read_stat("midrst_stat", 1'b1);

        rx_frame(8'hA3, 1'b1);
        read_stat("rx_a3_stat", 1'b1);
        read_data("rx_a3_data");
        read_stat("rx_a3_stat2", 1'b1);

        for (int i = 0; i < 3; i++) rx_frame(8'($urandom_range(0, 255)), 1'b1);
        for (int i = 0; i < 3; i++) read_data("rx_rand_data");
        read_stat("rx_rand_stat", 1'b1);

        for (int i = 0; i < 17; i++) rx_frame(8'($urandom_range(0, 255)), 1'b1);
        read_stat("rx_ovr_stat", 1'b1);
        read_stat("rx_ovr_cleared", 1'b1);
        for (int i = 0; i < 16; i++) read_data("rx_fill_data");
        read_data("rx_drained_data");
        read_stat("rx_drained_stat", 1'b1);

        rx_frame(8'($urandom_range(0, 255)), 1'b0);
        read_stat("rx_frm_stat", 1'b1);
        read_stat("rx_frm_cleared", 1'b1);

        rxd = 1'b0;
        repeat (20) @(negedge clk_10M);
        rxd = 1'b1;
        repeat (200) @(negedge clk_10M);
        read_stat("rx_glitch_stat", 1'b1);
        read_data("rx_glitch_data");

        rx_frame(8'h5C, 1'b1);
        read_data("rx_after_glitch_data");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
